divisor_secuencial: RTL and testbench

Sequential unsigned integer divider producing quotient and remainder for the arithmetic unit's DIV and MOD operations. It sits directly upstream of the arithmetic unit's result selector, which takes Q as the DIV result and M as the MOD result. It replaces a purely combinational divider with a restoring shift-subtract engine: one quotient bit per clock, with a start/busy/done handshake. Control logic sequences it and holds the ALU result stage until `done`.

---
 rtl/divisor_secuencial.sv | 129 ++++++++++++
 tb/tb_divisor_secuencial.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/divisor_secuencial.sv
// -----------------------------------------------------------------------------
// divisor_secuencial
//
// Sequential unsigned divider feeding the ALU result selector (Q -> DIV,
// M -> MOD). Restoring shift-subtract engine that retires one quotient bit
// per clock. Operands are captured on the accepting edge only. Results are
// held in output registers until the next completion.
//
// Ports:
//   clk      - system clock, all state changes on the rising edge
//   rst      - synchronous, active-low reset
//   start    - division request, honoured only while idle
//   A, B     - dividend / divisor (unsigned), sampled on the accepting edge
//   Q, M     - quotient / remainder registers
//   busy     - high whenever the engine is not idle
//   done     - one-cycle pulse, Q/M/div_zero are valid
//   div_zero - last completed operation had B = 0
// -----------------------------------------------------------------------------
module divisor_secuencial #(
    parameter int NUM_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [NUM_BITS-1:0] A,
    input  logic [NUM_BITS-1:0] B,
    output logic [NUM_BITS-1:0] Q,
    output logic [NUM_BITS-1:0] M,
    output logic                busy,
    output logic                done,
    output logic                div_zero
);

    localparam int CW = $clog2(NUM_BITS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    logic [NUM_BITS-1:0] d;      // latched divisor
    logic [NUM_BITS-1:0] qs;     // dividend in, quotient out (shifts left)
    logic [CW-1:0]       cnt;    // restoring steps still to perform

    // Partial remainder. After every restoring step it is strictly below the
    // divisor, so its extra top bit is always zero; only the low NUM_BITS
    // bits are stored, and the shifted-in value T carries the full width.
    logic [NUM_BITS-1:0] p;

    logic [NUM_BITS:0]   t;
    logic                ge;
    logic [NUM_BITS-1:0] diff;
    logic [NUM_BITS-1:0] p_next;
    logic [NUM_BITS-1:0] qs_next;

    // One restoring step: shift the next dividend bit into the remainder,
    // subtract the divisor if it fits, and shift the outcome into QS.
    always_comb begin
        t       = {p, qs[NUM_BITS-1]};
        ge      = (t >= {1'b0, d});
        // Only the low bits of T - D matter: when ge is set the true
        // difference is below D and therefore fits in NUM_BITS bits.
        diff    = t[NUM_BITS-1:0] - d;
        p_next  = ge ? diff : t[NUM_BITS-1:0];
        qs_next = {qs[NUM_BITS-2:0], ge};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            d        <= '0;
            qs       <= '0;
            p        <= '0;
            cnt      <= '0;
            Q        <= '0;
            M        <= '0;
            div_zero <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        d   <= B;
                        qs  <= A;
                        p   <= '0;
                        cnt <= CW'(NUM_BITS);
                        if (B == '0) begin
                            // Division by zero completes immediately with a
                            // saturated quotient and the dividend as remainder.
                            Q        <= '1;
                            M        <= A;
                            div_zero <= 1'b1;
                            state    <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end

                CALC: begin
                    qs  <= qs_next;
                    p   <= p_next;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        // Last step: publish the result in the same edge.
                        Q        <= qs_next;
                        M        <= p_next;
                        div_zero <= 1'b0;
                        state    <= DONE;
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Pure decodes of the state register: no path from start/A/B.
    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_divisor_secuencial.sv
// -----------------------------------------------------------------------------
// Self-checking bench for divisor_secuencial (NUM_BITS = 4).
// A transaction-level model predicts busy/done/Q/M/div_zero from plain
// integer division and the documented latencies; a negedge process compares
// every cycle. Directed scenarios add literal expectations.
// -----------------------------------------------------------------------------
module tb_divisor_secuencial;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] A = '0;
    logic [N-1:0] B = '0;
    logic [N-1:0] Q;
    logic [N-1:0] M;
    logic         busy;
    logic         done;
    logic         div_zero;

    int n_cmp = 0;
    int n_mis = 0;

    divisor_secuencial #(.NUM_BITS(N)) dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
        .Q(Q), .M(M), .busy(busy), .done(done), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Tracks one operation at a time: edges remaining until the result
    // appears, and the expected result from integer / and %.
    int  m_q = 0, m_m = 0, m_dz = 0;
    int  m_busy = 0, m_done = 0;
    int  m_left = 0;
    int  pend_q = 0, pend_m = 0;

    always @(posedge clk) begin
        if (!rst) begin
            m_q = 0; m_m = 0; m_dz = 0;
            m_busy = 0; m_done = 0; m_left = 0;
        end else if (m_done != 0) begin
            m_done = 0;
            m_busy = 0;
        end else if (m_busy != 0) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_done = 1;
                m_q = pend_q; m_m = pend_m; m_dz = 0;
            end
        end else if (start) begin
            m_busy = 1;
            if (B == 0) begin
                m_done = 1;
                m_q = (1 << N) - 1; m_m = int'(A); m_dz = 1;
            end else begin
                pend_q = int'(A) / int'(B);
                pend_m = int'(A) % int'(B);
                m_left = N;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        n_cmp++;
        if (busy !== m_busy[0] || done !== m_done[0] || div_zero !== m_dz[0] ||
            Q !== m_q[N-1:0] || M !== m_m[N-1:0]) begin
            n_mis++;
            $display("FAIL cycle t=%0t: got busy=%b done=%b dz=%b Q=%0d M=%0d, expected busy=%0d done=%0d dz=%0d Q=%0d M=%0d",
                     $time, busy, done, div_zero, Q, M, m_busy, m_done, m_dz, m_q, m_m);
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Issue one start pulse and wait (bounded) for done.
    // cyc = negedges after the accepting edge until done was seen.
    task automatic run_div(input int a, input int b, output int cyc);
        @(negedge clk);
        A = a[N-1:0]; B = b[N-1:0]; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 20) check("done_timeout", 0, 1);
    endtask

    int cyc;
    int ndone;
    int rises[$];
    int prev_busy;

    initial begin
        // 1. Reset
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_Q", int'(Q), 0);
        check("rst_M", int'(M), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_dz", int'(div_zero), 0);
        rst = 1'b1;

        // 2. Basic 13/3 with latency
        @(negedge clk);
        A = 4'd13; B = 4'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("basic_busy_after_accept", int'(busy), 1);
        check("basic_no_early_done", int'(done), 0);
        cyc = 0;
        while (done !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("basic_latency", cyc, 4);
        check("basic_Q", int'(Q), 4);
        check("basic_M", int'(M), 1);
        check("basic_dz", int'(div_zero), 0);
        @(negedge clk);
        check("basic_idle_after", int'(busy), 0);
        check("basic_done_one_cycle", int'(done), 0);

        // 3. Boundary operands
        run_div(15, 1, cyc);  check("b15_1_Q", int'(Q), 15); check("b15_1_M", int'(M), 0);
        run_div(2, 9, cyc);   check("b2_9_Q", int'(Q), 0);   check("b2_9_M", int'(M), 2);
        run_div(0, 5, cyc);   check("b0_5_Q", int'(Q), 0);   check("b0_5_M", int'(M), 0);
        run_div(15, 15, cyc); check("b15_15_Q", int'(Q), 1); check("b15_15_M", int'(M), 0);

        // 4. Divide by zero, then a normal run clears the flag
        run_div(7, 0, cyc);
        check("dz_latency", cyc, 0);
        check("dz_Q", int'(Q), 15);
        check("dz_M", int'(M), 7);
        check("dz_flag", int'(div_zero), 1);
        run_div(9, 2, cyc);
        check("after_dz_Q", int'(Q), 4);
        check("after_dz_M", int'(M), 1);
        check("after_dz_flag", int'(div_zero), 0);

        // 5. Start while busy and operand churn are ignored
        @(negedge clk);
        A = 4'd13; B = 4'd3; start = 1'b1;
        @(negedge clk);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            start = (i < 3);
            A = (i == 0) ? 4'd6 : 4'($urandom);
            B = (i == 0) ? 4'd2 : 4'($urandom);
            if (i < 4) check("churn_Q_held", int'(Q), 4);
            if (done === 1'b1) begin
                ndone++;
                check("churn_Q", int'(Q), 4);
                check("churn_M", int'(M), 1);
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("churn_done_pulses", ndone, 1);

        // 6. Abort on the second CALC edge, then back-to-back with start held
        @(negedge clk);
        A = 4'd13; B = 4'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("abort_busy", int'(busy), 0);
        check("abort_Q", int'(Q), 0);
        check("abort_M", int'(M), 0);
        ndone = 0;
        repeat (6) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        check("abort_no_done", ndone, 0);

        A = 4'd10; B = 4'd4; start = 1'b1;
        prev_busy = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (busy === 1'b1 && prev_busy == 0) rises.push_back(c);
            prev_busy = (busy === 1'b1) ? 1 : 0;
            if (done === 1'b1) begin
                check("b2b_Q", int'(Q), 2);
                check("b2b_M", int'(M), 2);
            end
        end
        start = 1'b0;
        check("b2b_accept_count_ge3", (rises.size() >= 3) ? 1 : 0, 1);
        for (int i = 1; i < rises.size(); i++)
            check("b2b_spacing", rises[i] - rises[i-1], 6);
        repeat (8) @(negedge clk);

        // Randomized traffic, including occasional B=0 and resets
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            start = ($urandom_range(0, 9) < 4);
            A = 4'($urandom);
            B = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom);
            rst = ($urandom_range(0, 199) != 0);
        end
        rst = 1'b1;
        start = 1'b0;
        repeat (10) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
